layer_out_serializer: RTL and testbench
=======================================

# layer_out_serializer

Downstream stage of a hidden layer. Collects the parallel activation outputs of all `numNeurons` neurons in that layer, then streams them one word per cycle as the `myinput`/`myinputValid` feed for every neuron of the next layer. Neuron outputs may complete in any cycle, so this block tolerates skew between the per-neuron `outvalid` pulses.

## Interface
Parameters:
- `numNeurons`, default 30: neurons in the producing layer, and therefore words per output frame.
- `dataWidth`, default 16: activation word width.
- `idxWidth`, default `$clog2(numNeurons)`: width of the stream index.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `x_valid`, in, `numNeurons`: per-neuron `outvalid` pulses. Bit i belongs to neuron i.
- `x_in`, in, `numNeurons*dataWidth`: neuron outputs. Neuron i occupies bits `[i*dataWidth +: dataWidth]`.
- `out_data`, out, `dataWidth`: streamed word, connected to the next layer's `myinput`.
- `out_valid`, out, 1: stream valid, connected to the next layer's `myinputValid`.
- `out_idx`, out, `idxWidth`: index of the word currently on `out_data`.
- `busy`, out, 1: high while the block is in SEND.
- `overrun`, out, 1: sticky error flag.

## Operation
State machine states:
- IDLE: capture mask is zero.
- COLLECT: mask is non-zero and not yet full.
- SEND: streaming the captured frame.

Capture (IDLE or COLLECT):
- For every i with `x_valid[i]`=1, register slice i of `x_in` into `buf[i]` and set `mask[i]`.
- Multiple bits may be set in the same cycle.
- IDLE moves to COLLECT on the first capture.
- When the mask becomes all ones, move to SEND with `idx`=0. This includes the case where every bit arrives in one cycle, which goes straight from IDLE to SEND.
- A pulse on an already-set mask bit overwrites `buf[i]` (the latest value wins) and sets `overrun`.

SEND:
- Each cycle, `out_data`<=`buf[idx]`, `out_idx`<=`idx`, `out_valid`<=1, then `idx` increments.
- After `idx`=`numNeurons-1` has been issued, clear the mask, reset `idx` to 0 and return to IDLE.
- Any `x_valid` bit set during SEND is dropped and sets `overrun`.

Other rules:
- `overrun` is cleared only by reset.
- Data is passed through unmodified: no arithmetic, no sign change. Words are signed fixed point, treated as opaque.
- Reset values: all outputs 0, state IDLE, mask 0, `idx` 0. `buf` contents are don't-care after reset.
- Reset asserted mid-COLLECT or mid-SEND aborts the frame immediately. `out_valid` drops asynchronously and no partial frame resumes.

## Timing
- All outputs are registered.
- If the last missing `x_valid` bit is high in cycle t, then `out_valid`=1 in cycles t+2 through t+1+`numNeurons`, with `out_idx` running 0…`numNeurons-1` contiguously (no gaps).
- `busy`=1 in cycles t+1 through t+`numNeurons`.
- The state is IDLE again from cycle t+1+`numNeurons`. An `x_valid` pulse in that cycle is captured normally.
- The next layer's neurons depend on a contiguous valid run: `out_valid` never deasserts within a frame.
- No backpressure. The downstream layer must accept one word per cycle.

## Structure
- The shared package holds:
  - the `ser_state_t` enum (IDLE, COLLECT, SEND);
  - the localparam for the default layer size, so it matches the neuron instances' `numWeight`.
- Single module. No sub-module is warranted: `buf` is a register array indexed by `idx` and needs no memory macro.

## Test plan
- Simultaneous capture, `numNeurons`=4, `dataWidth`=16: all 4 bits of `x_valid` pulse in cycle 0 with values 0x0001, 0x0002, 0x8000, 0x7FFF → `out_valid` in cycles 2–5, data in that order, `out_idx` 0–3, `busy` in cycles 1–4, `overrun`=0.
- Skewed capture: bits 3, 0, 2, 1 pulse in cycles 0, 3, 4, 9 → no output before cycle 11, then 4 contiguous words in index order.
- Duplicate pulse: bit 1 pulses with 0x00AA, then with 0x00BB before the frame completes → word 1 streams as 0x00BB, `overrun`=1 and stays 1 through later frames.
- Pulse during SEND: `x_valid[0]` fires in cycle 3 of a frame → streamed data unchanged, `overrun`=1, the next frame still needs all 4 bits.
- Reset mid-stream: `rst` driven low at cycle 3 → `out_valid`/`busy` immediately 0. After release, the block is in IDLE with an empty mask, and a fresh full `x_valid` streams correctly.
- Back-to-back frames: a new all-ones `x_valid` arrives in the first IDLE cycle after a frame (t+1+`numNeurons`) → it is captured, and the next stream starts 2 cycles later.

Source files
------------

// File: rtl/layer_out_serializer_pkg.sv
// rtl/layer_out_serializer_pkg.sv - shared types and default sizes for the layer output serializer
package layer_out_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } ser_state_t;

  // Must track numWeight of the next layer's neuron instances.
  localparam int DEFAULT_NUM_NEURONS = 30;
  localparam int DEFAULT_DATA_WIDTH  = 16;

endpackage

// File: rtl/layer_out_serializer_if.sv
// rtl/layer_out_serializer_if.sv - parallel neuron capture bus plus next-layer stream outputs
interface layer_out_serializer_if
  import layer_out_serializer_pkg::*;
#(
  parameter int numNeurons = DEFAULT_NUM_NEURONS,
  parameter int dataWidth  = DEFAULT_DATA_WIDTH,
  parameter int idxWidth   = $clog2(numNeurons)
);

  logic [numNeurons-1:0]           x_valid;
  logic [numNeurons*dataWidth-1:0] x_in;
  logic [dataWidth-1:0]            out_data;
  logic                            out_valid;
  logic [idxWidth-1:0]             out_idx;
  logic                            busy;
  logic                            overrun;

  // master: producing layer + downstream consumer side; slave: the serializer
  modport master (
    output x_valid, x_in,
    input  out_data, out_valid, out_idx, busy, overrun
  );

  modport slave (
    input  x_valid, x_in,
    output out_data, out_valid, out_idx, busy, overrun
  );

endinterface

// File: rtl/layer_out_serializer.sv
// rtl/layer_out_serializer.sv - collects skewed per-neuron outputs, then streams one word per cycle
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int numNeurons = DEFAULT_NUM_NEURONS,
  parameter int dataWidth  = DEFAULT_DATA_WIDTH,
  parameter int idxWidth   = $clog2(numNeurons)
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_out_serializer_if.slave bus
);

  localparam logic [numNeurons-1:0] FULL_MASK = '1;
  localparam logic [idxWidth-1:0]   LAST_IDX  = idxWidth'(numNeurons - 1);

  ser_state_t            state_q, state_d;
  logic [numNeurons-1:0] mask_q, mask_d;
  logic [idxWidth-1:0]   idx_q, idx_d;
  logic                  overrun_q, overrun_d;
  logic [numNeurons-1:0] cap;
  logic [dataWidth-1:0]  buf_q [numNeurons];

  logic [dataWidth-1:0]  out_data_q;
  logic                  out_valid_q;
  logic [idxWidth-1:0]   out_idx_q;
  logic                  busy_q;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    cap       = '0;
    case (state_q)
      IDLE, COLLECT: begin
        cap    = bus.x_valid;
        mask_d = mask_q | bus.x_valid;
        if ((bus.x_valid & mask_q) != '0) overrun_d = 1'b1;
        if (mask_d == FULL_MASK) begin
          state_d = SEND;
          idx_d   = '0;
        end else if (mask_d != '0) begin
          state_d = COLLECT;
        end
      end
      SEND: begin
        // No capture path while streaming: late pulses are lost, only flagged.
        if (bus.x_valid != '0) overrun_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          mask_d  = '0;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
      out_valid_q <= (state_q == SEND);
      busy_q      <= (state_d == SEND);
      if (state_q == SEND) begin
        out_data_q <= buf_q[idx_q];
        out_idx_q  <= idx_q;
      end
    end
  end

  // Frame buffer needs no reset: the mask guards every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeurons; i++) begin
      if (cap[i]) buf_q[i] <= bus.x_in[i*dataWidth +: dataWidth];
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb/tb_layer_out_serializer.sv - directed self-checking bench for layer_out_serializer
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_out_serializer_if #(.numNeurons(N), .dataWidth(W), .idxWidth(IW)) bus ();

  layer_out_serializer #(.numNeurons(N), .dataWidth(W), .idxWidth(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_w [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    bus.x_in[i*W +: W] = v;
  endtask

  // Called in the cycle t where the last missing bit is driven; checks t+1 .. t+1+N.
  task automatic expect_frame(input int inj_cycle, input logic [N-1:0] inj_mask,
                              input logic [W-1:0] inj_val, input bit tail, input logic exp_ovr);
    for (int c = 1; c <= N + 1; c++) begin
      tick();
      if (c == inj_cycle) begin
        bus.x_valid = inj_mask;
        for (int i = 0; i < N; i++) if (inj_mask[i]) set_word(i, inj_val + W'(i));
      end else begin
        bus.x_valid = '0;
      end
      checks++;
      if (bus.busy !== (c <= N)) begin
        errors++;
        $display("FAIL frame_busy cycle %0d got %b want %b", c, bus.busy, (c <= N));
      end
      checks++;
      if (bus.out_valid !== (c >= 2)) begin
        errors++;
        $display("FAIL frame_valid cycle %0d got %b want %b", c, bus.out_valid, (c >= 2));
      end
      if (c >= 2) begin
        checks++;
        if (bus.out_idx !== IW'(c - 2)) begin
          errors++;
          $display("FAIL frame_idx cycle %0d got %0d want %0d", c, bus.out_idx, c - 2);
        end
        checks++;
        if (bus.out_data !== exp_w[c-2]) begin
          errors++;
          $display("FAIL frame_data cycle %0d got %h want %h", c, bus.out_data, exp_w[c-2]);
        end
      end
      if (c == N + 1) begin
        checks++;
        if (bus.overrun !== exp_ovr) begin
          errors++;
          $display("FAIL frame_overrun got %b want %b", bus.overrun, exp_ovr);
        end
      end
    end
    if (tail) begin
      tick();
      bus.x_valid = '0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL frame_tail got valid %b busy %b want 0 0", bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.x_valid = '0;
    bus.x_in = '0;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    checks++;
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    checks++;
    if (bus.out_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.out_idx); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    exp_w[0] = 16'h0001; exp_w[1] = 16'h0002; exp_w[2] = 16'h8000; exp_w[3] = 16'h7FFF;
    for (int i = 0; i < N; i++) set_word(i, exp_w[i]);
    bus.x_valid = '1;
    expect_frame(0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_skewed();
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'hF444;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick();
      case (c)
        0: begin bus.x_valid = 4'b1000; set_word(3, exp_w[3]); end
        3: begin bus.x_valid = 4'b0001; set_word(0, exp_w[0]); end
        4: begin bus.x_valid = 4'b0100; set_word(2, exp_w[2]); end
        9: begin bus.x_valid = 4'b0010; set_word(1, exp_w[1]); end
        default: bus.x_valid = '0;
      endcase
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL skew_early cycle %0d got valid %b busy %b want 0 0", c, bus.out_valid, bus.busy);
      end
    end
    expect_frame(0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_pulse_during_send();
    exp_w[0] = 16'hA000; exp_w[1] = 16'hA001; exp_w[2] = 16'hA002; exp_w[3] = 16'hA003;
    for (int i = 0; i < N; i++) set_word(i, exp_w[i]);
    bus.x_valid = '1;
    expect_frame(3, 4'b0001, 16'hDEAD, 1'b1, 1'b1);
    exp_w[1] = 16'h0C01; exp_w[2] = 16'h0C02; exp_w[3] = 16'h0C03; exp_w[0] = 16'h0BAD;
    for (int i = 1; i < N; i++) set_word(i, exp_w[i]);
    bus.x_valid = 4'b1110;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.x_valid = '0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL send_drop_partial cycle %0d got valid %b busy %b want 0 0", c, bus.out_valid, bus.busy);
      end
    end
    set_word(0, exp_w[0]);
    bus.x_valid = 4'b0001;
    expect_frame(0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < N; i++) set_word(i, 16'h7700 + W'(i));
    bus.x_valid = '1;
    tick();
    bus.x_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got valid %b busy %b want 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", bus.overrun); end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_resume cycle %0d got valid %b busy %b want 0 0", c, bus.out_valid, bus.busy);
      end
    end
    exp_w[0] = 16'h0123; exp_w[1] = 16'h4567; exp_w[2] = 16'h89AB; exp_w[3] = 16'hCDEF;
    for (int i = 0; i < N; i++) set_word(i, exp_w[i]);
    bus.x_valid = '1;
    expect_frame(0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_duplicate();
    exp_w[0] = 16'h0010; exp_w[1] = 16'h00BB; exp_w[2] = 16'h0030; exp_w[3] = 16'h0040;
    set_word(1, 16'h00AA);
    bus.x_valid = 4'b0010;
    tick();
    bus.x_valid = '0;
    tick();
    set_word(1, 16'h00BB);
    bus.x_valid = 4'b0010;
    tick();
    set_word(0, exp_w[0]); set_word(2, exp_w[2]); set_word(3, exp_w[3]);
    bus.x_valid = 4'b1101;
    expect_frame(0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_w[0] = 16'h6000; exp_w[1] = 16'h6001; exp_w[2] = 16'h6002; exp_w[3] = 16'h6003;
    for (int i = 0; i < N; i++) set_word(i, exp_w[i]);
    bus.x_valid = '1;
    expect_frame(N + 1, '1, 16'h5000, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) exp_w[i] = 16'h5000 + W'(i);
    expect_frame(0, '0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_skewed();
    test_pulse_during_send();
    test_reset_mid_stream();
    test_duplicate();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
